mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, meaning the maximum number of BUSY cycles spent waiting for mem_ack before the access is aborted.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 validE / RegWriteE / MemReadE / MemWriteE / MemSignedE  in  1 each  op-valid and control bits from EX.
REQ-005 MemSizeE  in  2  access size: 00 byte, 01 half, 10 word (11 treated as word).
REQ-006 alu_outE  in  32  effective address or ALU result; r2_doutE  in  32  store data; r3_addrE  in  5  destination register.
REQ-007 flushM  in  1  kill the op held in the stage.
REQ-008 mem_req, mem_we  out  1 each  bus request and write strobe; mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}); mem_be  out  4  byte enables; mem_wdata  out  32  lane-replicated store data.
REQ-009 mem_ack  in  1  bus completion; mem_rdata  in  32  read word, valid when mem_ack=1.
REQ-010 stallM  out  1  upstream hold request.
REQ-011 validM, RegWriteM, excM  out  1 each; r3_addrM  out  5; resultM  out  32  registered MEM/WB outputs.

Function
REQ-012 Stage register SHALL capture all E inputs on an edge where stallM=0; it SHALL hold its contents while stallM=1.
REQ-013 FSM states SHALL be IDLE and BUSY; IDLE->BUSY when the held op is valid, not flushed, aligned, and has MemReadE or MemWriteE set; BUSY->IDLE on mem_ack=1 or on timeout.
REQ-014 mem_req SHALL be 1 exactly while the FSM is in BUSY; mem_we=held MemWrite; MemWrite SHALL take priority when MemRead and MemWrite are both set.
REQ-015 stallM SHALL equal (held op needs or is in BUSY) AND NOT mem_ack (combinational), so that upstream advances in the ack cycle.
REQ-016 Non-memory op: resultM=alu_out and validM=1 in the cycle after the MEM cycle (two edges after EX capture).
REQ-017 Store byte enables: byte gives be=1<<addr[1:0] with wdata={4{r2[7:0]}}; half gives be=addr[1]?1100:0011 with wdata={2{r2[15:0]}}; word gives be=1111 with wdata=r2.
REQ-018 Load: selected lane from mem_rdata SHALL be sign-extended if MemSigned=1, otherwise zero-extended; result registered on the ack edge; validM=1 in the following cycle.
REQ-019 Misaligned access (half with addr[0]=1; word with addr[1:0]!=00) SHALL issue no bus request and SHALL produce validM=1, excM=1, RegWriteM=0 with MEM/WB latency.
REQ-020 A saturating 8-bit-or-wider BUSY counter SHALL abort when it reaches ACK_TIMEOUT: mem_req drops, excM=1, RegWriteM=0, validM=1.
REQ-021 flushM in IDLE SHALL invalidate the held op (validM=0 next cycle, no request); flushM in BUSY SHALL NOT abort the bus transaction, the access completes, and its result is discarded (validM=0).
REQ-022 mem_ack while IDLE SHALL be ignored; validE=0 SHALL produce a bubble with validM=0 and RegWriteM=0.
REQ-023 excM, validM and RegWriteM SHALL be single-cycle pulses per op.

Reset
REQ-024 rst=1 SHALL immediately force: FSM=IDLE, mem_req=0, mem_we=0, mem_be=0, stallM=0, validM=0, RegWriteM=0, excM=0, resultM=0, r3_addrM=0, timeout counter=0, held op invalid.
REQ-025 Reset during BUSY SHALL abandon the transaction; a later mem_ack SHALL be ignored.

Structure
REQ-026 Size codes (MEMSZ_B/H/W), FSM state encoding and the ACK_TIMEOUT default SHALL reside in shared package cpu_pkg.
REQ-027 Lane steering and extension SHALL be one combinational sub-module, mem_align; the FSM, counter and pipeline registers SHALL stay in mem_stage.

Verification
REQ-028 sw with alu_outE=0x100, r2=0xDEADBEEF, mem_ack on the 3rd BUSY cycle -> mem_be=1111, stallM=1 for 2 cycles, validM=1 with RegWriteM=0.
REQ-029 lb signed at addr 0x103 with rdata=0x80FF_FF_FF -> resultM=0xFFFFFF80; the same access as lbu -> resultM=0x00000080.
REQ-030 sh at 0x102 with r2=0x1234ABCD -> mem_be=1100 and mem_wdata=0xABCDABCD; lw at 0x102 -> no mem_req, excM=1, RegWriteM=0.
REQ-031 lw with no ack and ACK_TIMEOUT=4 -> mem_req high for exactly 4 cycles, then excM=1 and stallM=0.
REQ-032 Back-to-back add then lw (ack immediate) -> add result validM followed by load validM on consecutive cycles, with no stall cycle beyond the ack cycle.
REQ-033 rst pulse mid-BUSY followed by a late mem_ack -> all outputs 0 and no validM.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: memory size codes,
// MEM stage FSM encoding and held-op bundle.
package cpu_pkg;

   localparam logic [1:0] MEMSZ_B = 2'b00;
   localparam logic [1:0] MEMSZ_H = 2'b01;
   localparam logic [1:0] MEMSZ_W = 2'b10;

   localparam int ACK_TIMEOUT_DEF = 255;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mstate_e;

   typedef struct packed {
      logic        v;
      logic        rw;
      logic        rd;
      logic        wr;
      logic        sg;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [4:0]  r3;
   } mop_t;

   // Size code 11 behaves as a word access.
   function automatic logic misaligned(input logic [1:0] sz,
                                       input logic [1:0] a);
      logic m;
      case (sz)
         MEMSZ_B: m = 1'b0;
         MEMSZ_H: m = a[0];
         default: m = (a != 2'b00);
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane select plus extension
// for loads.
module mem_align
   import cpu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sext,
   input  logic [31:0] sdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ldata
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      be    = 4'b1111;
      wdata = sdata;
      ldata = rdata;
      b     = rdata[{lane, 3'b000} +: 8];
      h     = lane[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         MEMSZ_B: begin
            be    = 4'b0001 << lane;
            wdata = {4{sdata[7:0]}};
            ldata = {{24{sext & b[7]}}, b};
         end
         MEMSZ_H: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{sdata[15:0]}};
            ldata = {{16{sext & h[15]}}, h};
         end
         default: begin
            be    = 4'b1111;
            wdata = sdata;
            ldata = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one op, runs the bus handshake with
// an ack timeout, and registers the MEM/WB outputs.
module mem_stage
   import cpu_pkg::*;
#(
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        validE,
   input  logic        RegWriteE,
   input  logic        MemReadE,
   input  logic        MemWriteE,
   input  logic        MemSignedE,
   input  logic [1:0]  MemSizeE,
   input  logic [31:0] alu_outE,
   input  logic [31:0] r2_doutE,
   input  logic [4:0]  r3_addrE,
   input  logic        flushM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stallM,
   output logic        validM,
   output logic        RegWriteM,
   output logic        excM,
   output logic [4:0]  r3_addrM,
   output logic [31:0] resultM
);

   localparam int CW = (ACK_TIMEOUT > 255) ?
                       $clog2(ACK_TIMEOUT + 1) : 8;

   mstate_e        st_q, st_d;
   mop_t           op_q, op_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    cnt_ext;

   logic           validM_q, validM_d;
   logic           rwM_q, rwM_d;
   logic           excM_q, excM_d;
   logic [4:0]     r3M_q, r3M_d;
   logic [31:0]    resM_q, resM_d;

   logic           busy, tmo, mem_e, mis_h, ld_h;
   logic [3:0]     be_a;
   logic [31:0]    ld_a;

   assign busy    = (st_q == ST_BUSY);
   assign cnt_ext = 32'(cnt_q);
   assign tmo     = busy & (cnt_ext + 32'd1 >= 32'(ACK_TIMEOUT));
   assign mem_e   = validE & (MemReadE | MemWriteE) &
                    ~misaligned(MemSizeE, alu_outE[1:0]);
   assign mis_h   = (op_q.rd | op_q.wr) &
                    misaligned(op_q.sz, op_q.addr[1:0]);
   assign ld_h    = op_q.rd & ~op_q.wr;

   mem_align u_align (
      .size  (op_q.sz),
      .lane  (op_q.addr[1:0]),
      .sext  (op_q.sg),
      .sdata (op_q.wd),
      .rdata (mem_rdata),
      .be    (be_a),
      .wdata (mem_wdata),
      .ldata (ld_a)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st_q <= ST_IDLE;
      else     st_q <= st_d;
   end

   // The incoming op decides BUSY on its capture edge, so a
   // memory op spends its first MEM cycle already on the bus.
   always_comb begin
      st_d = st_q;
      if (!stallM) st_d = mem_e ? ST_BUSY : ST_IDLE;
   end

   always_comb begin
      mem_req  = busy;
      mem_we   = busy & op_q.wr;
      mem_be   = busy ? be_a : 4'b0000;
      mem_addr = {op_q.addr[31:2], 2'b00};
      stallM   = busy & ~mem_ack & ~tmo;
   end

   always_comb begin
      op_d = op_q;
      if (!stallM) begin
         op_d.v    = validE;
         op_d.rw   = RegWriteE;
         op_d.rd   = MemReadE;
         op_d.wr   = MemWriteE;
         op_d.sg   = MemSignedE;
         op_d.sz   = MemSizeE;
         op_d.addr = alu_outE;
         op_d.wd   = r2_doutE;
         op_d.r3   = r3_addrE;
      end else if (flushM) begin
         op_d.v = 1'b0;
      end
   end

   always_comb begin
      cnt_d = '0;
      if (stallM) cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
   end

   // A BUSY op leaving without ack has timed out.
   always_comb begin
      validM_d = 1'b0;
      rwM_d    = 1'b0;
      excM_d   = 1'b0;
      r3M_d    = r3M_q;
      resM_d   = resM_q;
      if (!stallM && op_q.v && !flushM) begin
         validM_d = 1'b1;
         excM_d   = mis_h | (busy & ~mem_ack);
         rwM_d    = op_q.rw & ~excM_d;
         r3M_d    = op_q.r3;
         resM_d   = (busy & ld_h & mem_ack) ? ld_a : op_q.addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         cnt_q    <= '0;
         validM_q <= 1'b0;
         rwM_q    <= 1'b0;
         excM_q   <= 1'b0;
         r3M_q    <= '0;
         resM_q   <= '0;
      end else begin
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         validM_q <= validM_d;
         rwM_q    <= rwM_d;
         excM_q   <= excM_d;
         r3M_q    <= r3M_d;
         resM_q   <= resM_d;
      end
   end

   assign validM    = validM_q;
   assign RegWriteM = rwM_q;
   assign excM      = excM_q;
   assign r3_addrM  = r3M_q;
   assign resultM   = resM_q;

endmodule
